// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and helpers (tx FSM states, baud divider).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Clocks per bit, rounded to nearest integer.
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. A write while
//                full is accepted only if a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         din,
  output logic [width-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int c_AW = $clog2(depth);
  localparam logic [c_AW:0] c_FULL_CNT = (c_AW + 1)'(depth);

  logic [width-1:0] mem_q [depth];
  logic [c_AW-1:0]  wr_ptr_q;
  logic [c_AW-1:0]  rd_ptr_q;
  logic [c_AW:0]    count_q;
  logic [c_AW:0]    count_d;
  logic             w_wr;
  logic             w_rd;

  assign full  = (count_q == c_FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO can still take a write.
  assign w_rd    = pop && !empty;
  assign w_wr    = push && (!full || w_rd);
  assign count_d = count_q + (c_AW + 1)'(w_wr) - (c_AW + 1)'(w_rd);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (depth is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_wr) wr_ptr_q <= wr_ptr_q + c_AW'(1);
      if (w_rd) rd_ptr_q <= rd_ptr_q + c_AW'(1);
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Buffered 8N1 UART transmitter. Bytes are queued in a FIFO
//                and serialized back-to-back on the registered tx line.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int clkFreq  = 12_000_000,
  parameter int baudRate = 115200,
  parameter int depth    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       send_trigger,
  output logic       signal,
  output logic       busy,
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  localparam int c_BAUD_DIV = baud_div(clkFreq, baudRate);
  localparam int c_CNT_W    = $clog2(c_BAUD_DIV + 1);
  localparam logic [c_CNT_W-1:0] c_BAUD_RELOAD = c_CNT_W'(c_BAUD_DIV - 1);
  localparam logic [$clog2(depth):0] c_FULL_CNT = ($clog2(depth) + 1)'(depth);

  tx_state_t            state_q;
  logic [c_CNT_W-1:0]   baud_cnt_q;
  logic [2:0]           bit_idx_q;
  logic [7:0]           shreg_q;
  logic                 signal_q;
  logic                 busy_q;
  logic                 overflow_q;

  logic [7:0]           w_dout;
  logic                 w_fifo_full;
  logic                 w_empty;
  logic [$clog2(depth):0] w_count;
  logic                 w_bit_end;
  logic                 w_pop;

  sync_fifo #(
    .width (8),
    .depth (depth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (send_trigger),
    .pop   (w_pop),
    .din   (data),
    .dout  (w_dout),
    .full  (w_fifo_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_bit_end = (baud_cnt_q == '0);
  // Bytes leave the FIFO from IDLE, or at the last clock of STOP so frames abut.
  assign w_pop = !w_empty && ((state_q == IDLE) || ((state_q == STOP) && w_bit_end));

  assign signal   = signal_q;
  assign busy     = busy_q;
  assign empty    = w_empty;
  assign full     = (w_count == c_FULL_CNT);
  assign overflow = overflow_q;

  // Transmit FSM; line and busy are registered one clock behind the state so
  // every bit on the wire still lasts exactly c_BAUD_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      signal_q   <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      signal_q <= (state_q == START) ? 1'b0 :
                  (state_q == DATA)  ? shreg_q[0] : 1'b1;
      busy_q   <= (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (w_pop) begin
            shreg_q    <= w_dout;
            baud_cnt_q <= c_BAUD_RELOAD;
            state_q    <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            baud_cnt_q <= c_BAUD_RELOAD;
            bit_idx_q  <= '0;
            state_q    <= DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q - c_CNT_W'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            baud_cnt_q <= c_BAUD_RELOAD;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shreg_q   <= {1'b0, shreg_q[7:1]};
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - c_CNT_W'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              shreg_q    <= w_dout;
              baud_cnt_q <= c_BAUD_RELOAD;
              state_q    <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - c_CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // One-clock pulse when a strobe finds the FIFO full and nothing leaves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= send_trigger && w_fifo_full && !w_pop;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo. A line-level receiver
//                decodes frames; expected bytes come from a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int BD    = 104;      // 12 MHz / 115200 rounded
  localparam int FRAME = 10 * BD;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       send_trigger = 1'b0;
  logic       signal, busy, empty, full, overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ov_cnt = 0;
  int rst_seen = 0;
  logic [9:0] rx_frm[$];
  int         rx_st[$];

  uart_tx_fifo #(.clkFreq(12_000_000), .baudRate(115200), .depth(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .send_trigger(send_trigger),
    .signal(signal), .busy(busy), .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (overflow === 1'b1) ov_cnt <= ov_cnt + 1;
  always @(negedge rst_n) rst_seen <= rst_seen + 1;

  // Ideal 8N1 receiver: find the start edge, sample each bit at its centre.
  initial begin : rx_monitor
    logic [9:0] bits;
    int s, r0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && signal === 1'b0) begin
        s = cyc; r0 = rst_seen;
        repeat (BD / 2) @(negedge clk);
        bits[0] = signal;
        for (int i = 1; i < 10; i++) begin
          repeat (BD) @(negedge clk);
          bits[i] = signal;
        end
        if (rst_seen == r0) begin
          rx_frm.push_back(bits);
          rx_st.push_back(s);
        end
      end
    end
  end

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Strobe bytes on consecutive clocks; k_first is the first push edge.
  task automatic push_seq(input logic [7:0] b[$], output int k_first);
    k_first = 0;
    @(negedge clk);
    for (int i = 0; i < b.size(); i++) begin
      data = b[i]; send_trigger = 1'b1;
      @(negedge clk);
      if (i == 0) k_first = cyc;
    end
    send_trigger = 1'b0; data = 8'($urandom);
  endtask

  task automatic wait_rx(input int target, input int budget);
    int t = 0;
    while (rx_frm.size() < target && t < budget) begin @(negedge clk); t++; end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 30000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    int bad = 0; int ov0;
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (signal !== 1'b1) begin errors++; $display("FAIL reset_signal: got %b want 1", signal); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    repeat (3) @(negedge clk); rst_n = 1'b1;
    ov0 = ov_cnt;
    repeat (2000) begin
      @(negedge clk);
      if (signal !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet: got %0d bad clks want 0", bad); end
    checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL idle_overflow: got %0d pulses want 0", ov_cnt - ov0); end
  endtask

  task automatic test_single();
    int n0 = rx_frm.size(); int k; int n = 0;
    @(negedge clk); data = 8'hA5; send_trigger = 1'b1;
    @(negedge clk); send_trigger = 1'b0; data = 8'($urandom); k = cyc;
    checks++; if (signal !== 1'b1) begin errors++; $display("FAIL single_lat0: got %b want 1", signal); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_queued: empty %b want 0", empty); end
    @(negedge clk);
    checks++; if (signal !== 1'b1) begin errors++; $display("FAIL single_lat1: got %b want 1", signal); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_popped: empty %b want 1", empty); end
    @(negedge clk);
    checks++; if (signal !== 1'b0) begin errors++; $display("FAIL single_lat2: got %b want 0", signal); end
    while (busy === 1'b1 && n < 3000) begin n++; @(negedge clk); end
    checks++; if (n != FRAME) begin errors++; $display("FAIL single_busy_len: got %0d want %0d", n, FRAME); end
    wait_rx(n0 + 1, 200);
    checks++;
    if (rx_frm.size() != n0 + 1) begin
      errors++; $display("FAIL single_rx_count: got %0d want %0d", rx_frm.size() - n0, 1);
    end else begin
      checks++; if (rx_frm[n0] !== frame_of(8'hA5)) begin errors++; $display("FAIL single_bits: got %b want %b", rx_frm[n0], frame_of(8'hA5)); end
      checks++; if (rx_st[n0] != k + 2) begin errors++; $display("FAIL single_start: got %0d want %0d", rx_st[n0], k + 2); end
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int n0 = rx_frm.size(); int k; int t = 0;
    push_seq(q, k);
    while (cyc < k + 3 * FRAME) @(negedge clk);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL burst_empty_pre: got %b want 0", empty); end
    @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL burst_empty_post: got %b want 1", empty); end
    while (busy === 1'b1 && t < 6000) begin @(negedge clk); t++; end
    checks++; if (cyc - (k + 2) != 4 * FRAME) begin errors++; $display("FAIL burst_busy_span: got %0d want %0d", cyc - (k + 2), 4 * FRAME); end
    wait_rx(n0 + 4, 200);
    checks++;
    if (rx_frm.size() != n0 + 4) begin
      errors++; $display("FAIL burst_rx_count: got %0d want 4", rx_frm.size() - n0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rx_frm[n0+i] !== frame_of(q[i])) begin errors++; $display("FAIL burst_byte%0d: got %b want %b", i, rx_frm[n0+i], frame_of(q[i])); end
        checks++; if (rx_st[n0+i] != k + 2 + i * FRAME) begin errors++; $display("FAIL burst_start%0d: got %0d want %0d", i, rx_st[n0+i], k + 2 + i * FRAME); end
      end
    end
    wait_idle();
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int n0 = rx_frm.size(); int ov0 = ov_cnt;
    int nb = $urandom_range(5, 12);
    @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      data = 8'($urandom); send_trigger = 1'b1; exp_q.push_back(data);
      @(negedge clk);
      send_trigger = 1'b0; data = 8'($urandom);
    end
    wait_rx(n0 + nb, nb * FRAME + 2000);
    checks++;
    if (rx_frm.size() != n0 + nb) begin
      errors++; $display("FAIL rand_rx_count: got %0d want %0d", rx_frm.size() - n0, nb);
    end else begin
      for (int i = 0; i < nb; i++) begin
        checks++; if (rx_frm[n0+i] !== frame_of(exp_q[i])) begin errors++; $display("FAIL rand_byte%0d: got %b want %b", i, rx_frm[n0+i], frame_of(exp_q[i])); end
        if (i > 0) begin
          checks++; if (rx_st[n0+i] - rx_st[n0+i-1] != FRAME) begin errors++; $display("FAIL rand_gap%0d: got %0d want %0d", i, rx_st[n0+i] - rx_st[n0+i-1], FRAME); end
        end
      end
    end
    wait_idle();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rand_empty: got %b want 1", empty); end
    checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL rand_overflow: got %0d pulses want 0", ov_cnt - ov0); end
  endtask

  // Back-to-back writes from idle: first byte leaves one clock after it lands,
  // the next DEPTH fill the FIFO, so the (DEPTH+2)-th strobe is the one dropped.
  task automatic test_overflow();
    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    logic [7:0] extra;
    int n0 = rx_frm.size(); int ov0 = ov_cnt; int k; int pop_edge;
    for (int i = 0; i < DEPTH + 2; i++) q.push_back(8'($urandom));
    for (int i = 0; i < DEPTH + 1; i++) exp_q.push_back(q[i]);
    push_seq(q, k);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", full); end
    repeat (2) @(negedge clk);
    checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL ovf_pulses: got %0d want 1", ov_cnt - ov0); end
    pop_edge = k + 1 + FRAME;
    while (cyc < pop_edge - 1) @(negedge clk);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full_hold: got %b want 1", full); end
    extra = 8'($urandom); data = extra; send_trigger = 1'b1; exp_q.push_back(extra);
    @(negedge clk); send_trigger = 1'b0; data = 8'($urandom);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL coinc_full: got %b want 1", full); end
    repeat (3) @(negedge clk);
    checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL coinc_overflow: got %0d pulses want 1", ov_cnt - ov0); end
    wait_rx(n0 + exp_q.size(), exp_q.size() * FRAME + 2000);
    checks++;
    if (rx_frm.size() != n0 + exp_q.size()) begin
      errors++; $display("FAIL ovf_rx_count: got %0d want %0d", rx_frm.size() - n0, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (rx_frm[n0+i] !== frame_of(exp_q[i])) begin errors++; $display("FAIL ovf_byte%0d: got %b want %b", i, rx_frm[n0+i], frame_of(exp_q[i])); end
      end
    end
    wait_idle();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] q[$] = '{8'hFF, 8'h00};
    int n0 = rx_frm.size(); int k; int lows = 0;
    push_seq(q, k);
    while (cyc < k + 2 + 4 * BD + BD / 2) @(negedge clk);
    checks++; if (busy !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL midrst_pre: busy %b empty %b want 1 0", busy, empty); end
    rst_n = 1'b0; #1;
    checks++; if (signal !== 1'b1) begin errors++; $display("FAIL midrst_signal: got %b want 1", signal); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b want 1", empty); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk); rst_n = 1'b1;
    repeat (2500) begin @(negedge clk); if (signal !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL midrst_residual: got %0d low clks want 0", lows); end
    checks++; if (rx_frm.size() != n0) begin errors++; $display("FAIL midrst_frames: got %0d want 0", rx_frm.size() - n0); end
  endtask

  initial begin : watchdog
    #(2_000_000);
    errors++;
    $display("FAIL watchdog: time limit reached, got timeout want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_overflow();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
